data_cache_2way: RTL

DATA_CACHE_2WAY -- requirements
Module: data_cache_2way

---
 rtl/dcache_pkg.sv | 20 ++
 rtl/dcache_way.sv | 78 +++++++
 rtl/data_cache_2way.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types for the 2-way data cache: the controller state enum and the
// per-line metadata record exchanged between the top level and each way.
package dcache_pkg;

   // Tags travel zero-extended at this width; each way keeps only its real bits.
   localparam int DC_MAX_TAG_W = 64;

   typedef enum logic [1:0] {
      DC_IDLE      = 2'd0,
      DC_WRITEBACK = 2'd1,
      DC_REFILL    = 2'd2
   } dc_state_e;

   typedef struct packed {
      logic                    valid;
      logic                    dirty;
      logic [DC_MAX_TAG_W-1:0] tag;
   } dc_meta_t;

endpackage

// File: rtl/dcache_way.sv
// One way of the cache: valid/dirty bits (cleared by reset), plus tag and
// data arrays (not reset). A single index addresses both the asynchronous
// read port and the one write port. Data writes merge under a byte mask.
module dcache_way
   import dcache_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int SETS       = 64,
   parameter int TAG_W      = 24
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [$clog2(SETS)-1:0] idx_i,
   output dc_meta_t                rd_meta_o,
   output logic [DATA_WIDTH-1:0]   rd_data_o,
   input  logic                    wr_en_i,
   input  dc_meta_t                wr_meta_i,
   input  logic [DATA_WIDTH-1:0]   wr_data_i,
   input  logic [DATA_WIDTH/8-1:0] wr_be_i
);

   localparam int BE_W = DATA_WIDTH / 8;

   logic [SETS-1:0]       valid_q, valid_d;
   logic [SETS-1:0]       dirty_q, dirty_d;
   logic [TAG_W-1:0]      tag_q [SETS];
   logic [TAG_W-1:0]      tag_d;
   logic [DATA_WIDTH-1:0] data_q [SETS];
   logic [DATA_WIDTH-1:0] data_d;

   // Only the low TAG_W bits of the wide tag are stored.
   logic unused_wr_tag;
   assign unused_wr_tag = ^wr_meta_i.tag;

   // Asynchronous read of the addressed line.
   always_comb begin
      rd_meta_o       = '0;
      rd_meta_o.valid = valid_q[idx_i];
      rd_meta_o.dirty = dirty_q[idx_i];
      rd_meta_o.tag   = DC_MAX_TAG_W'(tag_q[idx_i]);
      rd_data_o       = data_q[idx_i];
   end

   // Next valid/dirty bits and the byte-merged word for the write port.
   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      tag_d   = TAG_W'(wr_meta_i.tag);
      data_d  = data_q[idx_i];
      for (int b = 0; b < BE_W; b++) begin
         if (wr_be_i[b]) data_d[8*b +: 8] = wr_data_i[8*b +: 8];
      end
      if (wr_en_i) begin
         valid_d[idx_i] = wr_meta_i.valid;
         dirty_d[idx_i] = wr_meta_i.dirty;
      end
   end

   // Line status bits; reset invalidates and cleans every line.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   // Tag and data storage; contents are meaningless until the line is valid.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         tag_q[idx_i]  <= tag_d;
         data_q[idx_i] <= data_d;
      end
   end

endmodule

// File: rtl/data_cache_2way.sv
// 2-way set-associative, write-back, write-allocate data cache with one word
// per line and one LRU bit per set. Optional hit/miss statistics counters
// exist only when DCACHE_STATS_EN is defined.
//
// Handshakes: the CPU holds every request input stable while stall_o is high;
// an access completes in the cycle where req_i=1 and stall_o=0. On the memory
// side mem_req_o and its address/data stay stable until a cycle with
// mem_ready_i=1, and that cycle completes the transfer.
module data_cache_2way
   import dcache_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int SETS       = 64
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_i,
   input  logic                    write_en_i,
   input  logic [DATA_WIDTH/8-1:0] byte_en_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [DATA_WIDTH-1:0]   write_data_i,
   output logic [DATA_WIDTH-1:0]   read_data_o,
   output logic                    stall_o,
   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   input  logic                    mem_ready_i,
`ifdef DCACHE_STATS_EN
   output logic [31:0]             hit_count_o,
   output logic [31:0]             miss_count_o,
`endif
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int OFF   = $clog2(BE_W);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_WIDTH - OFF - IDX_W;

   logic [IDX_W-1:0]        req_idx;
   logic [DC_MAX_TAG_W-1:0] req_tag;
   dc_meta_t                meta0, meta1, sel_meta, vic_meta;
   logic [DATA_WIDTH-1:0]   data0, data1, vic_data;
   logic                    match0, match1, hit0, hit1, hit, miss;
   logic                    victim_sel;
   logic [ADDR_WIDTH-1:0]   wb_addr, refill_addr;

   dc_state_e               state_q, state_d;
   logic                    victim_q, victim_d;
   logic [SETS-1:0]         lru_q, lru_d;

   logic                    we0, we1;
   dc_meta_t                wr_meta;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [BE_W-1:0]         wr_be;

   // The word-offset bits take no part in the lookup.
   logic unused_addr;
   assign unused_addr = ^addr_i;

   assign req_idx = addr_i[OFF +: IDX_W];
   assign req_tag = DC_MAX_TAG_W'(addr_i[ADDR_WIDTH-1 -: TAG_W]);

   dcache_way #(.DATA_WIDTH(DATA_WIDTH), .SETS(SETS), .TAG_W(TAG_W)) u_way0 (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .idx_i     (req_idx),
      .rd_meta_o (meta0),
      .rd_data_o (data0),
      .wr_en_i   (we0),
      .wr_meta_i (wr_meta),
      .wr_data_i (wr_data),
      .wr_be_i   (wr_be)
   );

   dcache_way #(.DATA_WIDTH(DATA_WIDTH), .SETS(SETS), .TAG_W(TAG_W)) u_way1 (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .idx_i     (req_idx),
      .rd_meta_o (meta1),
      .rd_data_o (data1),
      .wr_en_i   (we1),
      .wr_meta_i (wr_meta),
      .wr_data_i (wr_data),
      .wr_be_i   (wr_be)
   );

   // Lookup, victim choice and memory addresses; way 0 wins a double match.
   always_comb begin
      match0      = meta0.valid && (meta0.tag == req_tag);
      match1      = meta1.valid && (meta1.tag == req_tag);
      hit0        = (state_q == DC_IDLE) && req_i && match0;
      hit1        = (state_q == DC_IDLE) && req_i && match1 && !match0;
      hit         = hit0 || hit1;
      miss        = (state_q == DC_IDLE) && req_i && !hit;
      victim_sel  = !meta0.valid ? 1'b0 : (!meta1.valid ? 1'b1 : lru_q[req_idx]);
      sel_meta    = victim_sel ? meta1 : meta0;
      vic_meta    = victim_q ? meta1 : meta0;
      vic_data    = victim_q ? data1 : data0;
      wb_addr     = ADDR_WIDTH'({vic_meta.tag[TAG_W-1:0], req_idx}) << OFF;
      refill_addr = (addr_i >> OFF) << OFF;
   end

   // Controller next state, way writes, LRU update and all outputs.
   always_comb begin
      state_d     = state_q;
      victim_d    = victim_q;
      lru_d       = lru_q;
      we0         = 1'b0;
      we1         = 1'b0;
      wr_meta     = '0;
      wr_data     = '0;
      wr_be       = '0;
      read_data_o = '0;
      stall_o     = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      case (state_q)
         DC_IDLE: begin
            if (hit) begin
               read_data_o    = hit0 ? data0 : data1;
               lru_d[req_idx] = hit0;
               if (write_en_i) begin
                  we0     = hit0;
                  we1     = hit1;
                  wr_meta = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
                  wr_data = write_data_i;
                  wr_be   = byte_en_i;
               end
            end else if (miss) begin
               stall_o  = 1'b1;
               victim_d = victim_sel;
               state_d  = (sel_meta.valid && sel_meta.dirty) ? DC_WRITEBACK : DC_REFILL;
            end
         end
         DC_WRITEBACK: begin
            stall_o     = 1'b1;
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = wb_addr;
            mem_wdata_o = vic_data;
            if (mem_ready_i) state_d = DC_REFILL;
         end
         DC_REFILL: begin
            stall_o    = 1'b1;
            mem_req_o  = 1'b1;
            mem_addr_o = refill_addr;
            if (mem_ready_i) begin
               we0     = !victim_q;
               we1     = victim_q;
               wr_meta = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
               wr_data = mem_rdata_i;
               wr_be   = '1;
               state_d = DC_IDLE;
            end
         end
         default: state_d = DC_IDLE;
      endcase
   end

   // Controller state, latched victim way and per-set LRU bits.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= DC_IDLE;
         victim_q <= 1'b0;
         lru_q    <= '0;
      end else begin
         state_q  <= state_d;
         victim_q <= victim_d;
         lru_q    <= lru_d;
      end
   end

`ifdef DCACHE_STATS_EN
   logic        refill_done_q, refill_done_d;
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   // The hit right after a refill finishes a counted miss, so it is skipped.
   always_comb begin
      refill_done_d = (state_q == DC_REFILL) && mem_ready_i;
      hit_cnt_d     = hit_cnt_q + {31'd0, hit && !refill_done_q};
      miss_cnt_d    = miss_cnt_q + {31'd0, miss};
   end

   // Statistics registers; both wrap naturally at 2^32.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         refill_done_q <= 1'b0;
         hit_cnt_q     <= '0;
         miss_cnt_q    <= '0;
      end else begin
         refill_done_q <= refill_done_d;
         hit_cnt_q     <= hit_cnt_d;
         miss_cnt_q    <= miss_cnt_d;
      end
   end

   assign hit_count_o  = hit_cnt_q;
   assign miss_count_o = miss_cnt_q;
`endif

endmodule
